// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control / ALUOp encodings and the multiply
// sequencer state type.
package cpu_pkg;

    // ALU control codes driven by the ALU control decode
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // ALUOp from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Multiply sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiply datapath. Holds the accumulator, the shifting
// multiplicand and multiplier; the controller drives load/step.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] acc_next_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // Accumulator value after the current iteration; only the low half of
    // the product is ever kept, so the add simply wraps.
    assign acc_next_o = mplier[0] ? (acc + mcand) : acc;

    // Load operands on accept, otherwise advance one bit per step
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load_i) begin
            acc    <= '0;
            mcand  <= op_a_i;
            mplier <= op_b_i;
        end else if (step_i) begin
            acc    <= acc_next_o;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer for the EX stage: accepts a MUL, stalls the
// pipeline for WIDTH+1 cycles and pulses done_o with the low product half.
module mul_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mul_valid_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] acc_next;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .step_i     (step),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .acc_next_o (acc_next)
    );

    assign busy_o = (state != IDLE);

    // Datapath enables and the pipeline hold; the stall must be visible in
    // the accept cycle itself, hence combinational.
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        stall_o = 1'b0;
        case (state)
            IDLE: begin
                load    = mul_valid_i & ~flush_i;
                stall_o = mul_valid_i & ~flush_i;
            end
            RUN: begin
                step    = ~flush_i;
                stall_o = ~flush_i;
            end
            default: begin
                load    = 1'b0;
                step    = 1'b0;
                stall_o = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with iteration counter and registered done/result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (mul_valid_i && !flush_i) begin
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        // Squashed: drop the partial product, keep old result
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            result_o <= acc_next;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Instruction retires this cycle; new MULs wait for IDLE
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencer for the multi-cycle integer multiply in the EX stage.
- When the ALU control decode selects MUL (ALU control code 3'b011), this block takes the operands and runs a radix-2 shift-add multiply over WIDTH cycles.
- It holds the pipeline with a stall while it runs, then presents the low WIDTH bits of the product for one cycle.
- It sits beside the ALU and feeds the EX result mux and the hazard/stall logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (localparam, derived, not overridable).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- mul_valid_i  in  1  EX stage holds a valid MUL (ALU control == 3'b011).
- flush_i  in  1  EX stage instruction is squashed this cycle.
- op_a_i  in  WIDTH  multiplicand (rs data).
- op_b_i  in  WIDTH  multiplier (rt data).
- stall_o  out  1  freeze IF/ID/EX pipeline registers.
- busy_o  out  1  sequencer not IDLE.
- done_o  out  1  result_o valid this cycle (single-cycle pulse).
- result_o  out  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset (rst_i low, async):
  - state=IDLE; acc, mcand, mplier and cnt = 0.
  - stall_o=0, busy_o=0, done_o=0, result_o=0.
  - Reset asserted mid-RUN aborts immediately; no done_o is produced.
- States: IDLE, RUN, DONE. busy_o = (state != IDLE).
- IDLE:
  - If mul_valid_i & ~flush_i: latch mcand=op_a_i, mplier=op_b_i, acc=0, cnt=0, then go to RUN.
  - stall_o is combinational: stall_o = mul_valid_i & ~flush_i in IDLE, so the pipeline holds in the accept cycle.
- RUN, one iteration per cycle:
  - If mplier[0]: acc <= acc + mcand, truncated to WIDTH.
  - mcand <= mcand << 1; mplier <= mplier >> 1 (logical); cnt <= cnt + 1.
  - When cnt == WIDTH-1, the update is the final one; go to DONE.
  - stall_o = ~flush_i.
  - If flush_i: go to IDLE, discard acc, do not update result_o, no done_o.
- DONE:
  - done_o=1, stall_o=0, result_o=acc (registered; held until the next DONE or reset).
  - mul_valid_i is ignored here; the instruction retires at the end of this cycle. Always go to IDLE.
- Latency: accept cycle (IDLE) + WIDTH RUN cycles + DONE. done_o rises WIDTH+1 cycles after the accept cycle. stall_o is high for WIDTH+1 consecutive cycles.
- Arithmetic: only the low half of the product is kept, so the result is identical for signed and unsigned two's-complement operands. Overflow wraps silently.
- No early termination; latency is fixed regardless of operand values (including zero).
- Back-to-back MULs: the second is accepted in the IDLE cycle right after DONE. A gap of one DONE cycle between stall periods is required.
- flush_i together with mul_valid_i in IDLE: no accept, stall_o=0.
- flush_i in DONE: ignored; done_o still pulses, and the pipeline discards the result.

Decomposition:
- Shared package cpu_pkg:
  - ALU control encodings (ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_MUL=3'b011, ALU_SUB=3'b110).
  - ALUOp encodings.
  - State enum mul_state_t {IDLE, RUN, DONE}.
- One natural sub-module: mul_shift_add_dp.
  - Contents: acc/mcand/mplier registers, adder and shifts, driven by load/step enables from the FSM.
  - The FSM, counter and stall logic stay in mul_seq_ctrl.

Test Plan:
- Basic: op_a=3, op_b=5, mul_valid pulse held until done → stall_o high 33 cycles, done_o on cycle 33 after accept, result_o=15.
- Signed/wrap:
  - 0xFFFFFFFD × 7 → result_o=0xFFFFFFEB.
  - 0xFFFFFFFF × 2 → 0xFFFFFFFE.
  - 0x80000000 × 2 → 0x00000000.
- Zero/identity: 0 × 0x12345678 → 0 with full 33-cycle stall; 0xDEADBEEF × 1 → 0xDEADBEEF.
- Flush: start 6×7, assert flush_i on RUN cycle 10 → stall_o drops that cycle, next state IDLE, no done_o, result_o keeps its previous value.
- Reset mid-run: rst_i low on RUN cycle 5 → all outputs 0 immediately. After release, a new 4×4 runs normally → 16.
- Back-to-back: 2×3 then 4×5 → done_o pulses at cycles 33 and 67 (relative to first accept) with 6 then 20; stall_o low exactly on each DONE cycle.
